// File: rtl/datamover_cmd_arbiter_pkg.sv
// Shared constants and FSM encoding for the DataMover command/status arbiter.
package datamover_cmd_arbiter_pkg;

  localparam int DM_CMD_WIDTH     = 72;
  localparam int DM_CMD_TAG_LSB   = 64;
  localparam int DM_CMD_TAG_WIDTH = 4;
  localparam int DM_STS_ERR_LSB   = 4;
  localparam int DM_STS_ERR_WIDTH = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/datamover_id_fifo.sv
// In-order FIFO of 1-bit requester IDs; head names the owner of the next status beat.
module datamover_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push_i,
  input  logic       din_i,
  input  logic       pop_i,
  output logic       dout_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [4:0] count_o
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [4:0]       count_q;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == 5'd0);
  assign count_o = count_q;

endmodule

// File: rtl/datamover_cmd_arbiter.sv
// Round-robin sharing of one DataMover command/status pair between two requesters.
// Optional statistics counters are enabled with DATAMOVER_CMD_ARBITER_STATS_EN.
module datamover_cmd_arbiter
  import datamover_cmd_arbiter_pkg::*;
#(
  parameter int C_STS_WIDTH       = 8,
  parameter int C_MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DM_CMD_WIDTH-1:0] s0_axis_cmd_tdata,
  input  logic                    s0_axis_cmd_tvalid,
  output logic                    s0_axis_cmd_tready,
  input  logic [DM_CMD_WIDTH-1:0] s1_axis_cmd_tdata,
  input  logic                    s1_axis_cmd_tvalid,
  output logic                    s1_axis_cmd_tready,
  output logic [DM_CMD_WIDTH-1:0] m_axis_cmd_tdata,
  output logic                    m_axis_cmd_tvalid,
  input  logic                    m_axis_cmd_tready,
  input  logic [C_STS_WIDTH-1:0]  s_axis_sts_tdata,
  input  logic                    s_axis_sts_tvalid,
  output logic                    s_axis_sts_tready,
  output logic [C_STS_WIDTH-1:0]  m0_axis_sts_tdata,
  output logic                    m0_axis_sts_tvalid,
  input  logic                    m0_axis_sts_tready,
  output logic [C_STS_WIDTH-1:0]  m1_axis_sts_tdata,
  output logic                    m1_axis_sts_tvalid,
  input  logic                    m1_axis_sts_tready,
  output logic [4:0]              outstanding
`ifdef DATAMOVER_CMD_ARBITER_STATS_EN
  ,
  output logic [15:0]             grant_count0,
  output logic [15:0]             grant_count1,
  output logic [7:0]              sts_error_count
`endif
);

  // All streams use AXI-Stream rules: a beat transfers on a cycle where tvalid and
  // tready are both high; a source holds tvalid and tdata stable until that cycle.

  arb_state_e              state_q, state_d;
  logic                    prio_q;
  logic [DM_CMD_WIDTH-1:0] cmd_q;
  logic                    grant;
  logic                    winner;
  logic                    fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    sel_sts_ready;
  logic                    sts_pop;

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    winner  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((s0_axis_cmd_tvalid || s1_axis_cmd_tvalid) && !fifo_full) begin
          grant   = 1'b1;
          winner  = (s0_axis_cmd_tvalid && s1_axis_cmd_tvalid) ? prio_q : s1_axis_cmd_tvalid;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_axis_cmd_tready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // prio_q names the requester that wins a tie; it moves away from each winner.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        prio_q <= ~winner;
        cmd_q  <= winner ? s1_axis_cmd_tdata : s0_axis_cmd_tdata;
      end
    end
  end

  assign s0_axis_cmd_tready = grant && !winner;
  assign s1_axis_cmd_tready = grant && winner;
  assign m_axis_cmd_tdata   = cmd_q;
  assign m_axis_cmd_tvalid  = (state_q == ST_ISSUE);

  datamover_id_fifo #(
    .DEPTH(C_MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (grant),
    .din_i   (winner),
    .pop_i   (sts_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding)
  );

  // Status is steered by the FIFO head; with no owner on record it is held off.
  assign sel_sts_ready      = fifo_head ? m1_axis_sts_tready : m0_axis_sts_tready;
  assign s_axis_sts_tready  = !fifo_empty && sel_sts_ready;
  assign m0_axis_sts_tvalid = s_axis_sts_tvalid && !fifo_empty && !fifo_head;
  assign m1_axis_sts_tvalid = s_axis_sts_tvalid && !fifo_empty && fifo_head;
  assign m0_axis_sts_tdata  = s_axis_sts_tdata;
  assign m1_axis_sts_tdata  = s_axis_sts_tdata;
  assign sts_pop            = s_axis_sts_tvalid && s_axis_sts_tready;

`ifdef DATAMOVER_CMD_ARBITER_STATS_EN
  logic [15:0] grant_count0_q;
  logic [15:0] grant_count1_q;
  logic [7:0]  sts_error_count_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant_count0_q    <= '0;
      grant_count1_q    <= '0;
      sts_error_count_q <= '0;
    end else begin
      if (grant && !winner) grant_count0_q <= grant_count0_q + 16'd1;
      if (grant && winner)  grant_count1_q <= grant_count1_q + 16'd1;
      if (sts_pop && (|s_axis_sts_tdata[DM_STS_ERR_LSB +: DM_STS_ERR_WIDTH])
          && (sts_error_count_q != 8'hFF)) begin
        sts_error_count_q <= sts_error_count_q + 8'd1;
      end
    end
  end

  assign grant_count0    = grant_count0_q;
  assign grant_count1    = grant_count1_q;
  assign sts_error_count = sts_error_count_q;
`endif

endmodule
